pipe_stage_reg: RTL and testbench

- Generic, parametrised inter-stage pipeline register for the 5-stage MIPS core; successor to the fixed per-stage register files (D/E, E/M, M/W).
- Carries an opaque payload (PC, PC+8, ALU result, memory data, control bundles packed by the instantiating stage), the GRF write address/enable and the hazard timing field Tnew.
- Adds valid/ready handshake, stall hold, flush-to-bubble, saturating Tnew decrement, a forwarding-ready flag, and an optional skid entry.

---
 rtl/pipe_stage_reg.sv | 163 ++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic inter-stage pipeline register for the 5-stage MIPS core.
// Carries an opaque payload, the GRF write address/enable and the hazard
// timing field Tnew, with a valid/ready handshake, stall hold, flush-to-bubble
// and a saturating Tnew decrement applied once per stage traversal.
// Optional build macro: PIPE_STAGE_SKID_EN adds one skid entry and turns
// in_ready into a register, which breaks the out_ready -> in_ready path.
module pipe_stage_reg #(
   parameter int                 DATA_W   = 128,
   parameter int                 A3_W     = 5,
   parameter int                 TNEW_W   = 2,
   parameter logic [DATA_W-1:0]  DATA_RST = {DATA_W{1'b0}}
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [A3_W-1:0]   in_a3,
   input  logic              in_we,
   input  logic [TNEW_W-1:0] in_tnew,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [A3_W-1:0]   out_a3,
   output logic              out_we,
   output logic [TNEW_W-1:0] out_tnew,
   output logic              out_fwd_ok
);

   // Saturating Tnew decrement: a result already available stays available.
   function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
      if (t == '0)
         return '0;
      else
         return t - TNEW_W'(1);
   endfunction

   // A consumer may forward only from a real, writing, non-$0, finished result.
   function automatic logic fwd_ready(input logic               v,
                                      input logic               we,
                                      input logic [A3_W-1:0]    a3,
                                      input logic [TNEW_W-1:0]  t);
      return v & we & (a3 != '0) & (t == '0);
   endfunction

   // Output stage registers
   logic              vld_p0;
   logic [DATA_W-1:0] data_p0;
   logic [A3_W-1:0]   a3_p0;
   logic              we_p0;
   logic [TNEW_W-1:0] tnew_p0;

   // Output stage can take a new beat (empty or draining this cycle)
   logic              out_free;
   assign out_free = out_ready | ~vld_p0;

`ifdef PIPE_STAGE_SKID_EN

   // Skid entry: holds a beat accepted while the output stage was stalled.
   // Its Tnew is already decremented so the move to the output is a plain copy.
   logic              vld_p1;
   logic [DATA_W-1:0] data_p1;
   logic [A3_W-1:0]   a3_p1;
   logic              we_p1;
   logic [TNEW_W-1:0] tnew_p1;
   logic              rdy_q;

   assign in_ready = rdy_q;

   // Output stage and skid entry update; rdy_q always mirrors "skid empty"
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         vld_p0  <= 1'b0;
         data_p0 <= DATA_RST;
         a3_p0   <= '0;
         we_p0   <= 1'b0;
         tnew_p0 <= '0;
         vld_p1  <= 1'b0;
         data_p1 <= DATA_RST;
         a3_p1   <= '0;
         we_p1   <= 1'b0;
         tnew_p1 <= '0;
         rdy_q   <= 1'b1;
      end else if (vld_p1) begin
         // Skid occupied: nothing enters; drain it as soon as the output frees
         if (out_free) begin
            vld_p0  <= 1'b1;
            data_p0 <= data_p1;
            a3_p0   <= a3_p1;
            we_p0   <= we_p1;
            tnew_p0 <= tnew_p1;
            vld_p1  <= 1'b0;
            data_p1 <= DATA_RST;
            a3_p1   <= '0;
            we_p1   <= 1'b0;
            tnew_p1 <= '0;
            rdy_q   <= 1'b1;
         end
      end else if (out_free) begin
         // Skid empty, output free: capture the incoming beat or load a bubble
         vld_p0 <= in_valid;
         if (in_valid) begin
            data_p0 <= in_data;
            a3_p0   <= in_a3;
            we_p0   <= in_we;
            tnew_p0 <= tnew_dec(in_tnew);
         end else begin
            data_p0 <= DATA_RST;
            a3_p0   <= '0;
            we_p0   <= 1'b0;
            tnew_p0 <= '0;
         end
      end else if (in_valid) begin
         // Output stalled but the beat was accepted: park it in the skid
         vld_p1  <= 1'b1;
         data_p1 <= in_data;
         a3_p1   <= in_a3;
         we_p1   <= in_we;
         tnew_p1 <= tnew_dec(in_tnew);
         rdy_q   <= 1'b0;
      end
   end

`else

   // Without a skid, the stage accepts exactly when its output is free
   assign in_ready = out_free;

   // Output stage update: hold on stall, capture or bubble otherwise
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         vld_p0  <= 1'b0;
         data_p0 <= DATA_RST;
         a3_p0   <= '0;
         we_p0   <= 1'b0;
         tnew_p0 <= '0;
      end else if (out_free) begin
         vld_p0 <= in_valid;
         if (in_valid) begin
            data_p0 <= in_data;
            a3_p0   <= in_a3;
            we_p0   <= in_we;
            tnew_p0 <= tnew_dec(in_tnew);
         end else begin
            data_p0 <= DATA_RST;
            a3_p0   <= '0;
            we_p0   <= 1'b0;
            tnew_p0 <= '0;
         end
      end
   end

`endif

   assign out_valid  = vld_p0;
   assign out_data   = data_p0;
   assign out_a3     = a3_p0;
   assign out_we     = we_p0 & vld_p0;
   assign out_tnew   = tnew_p0;
   assign out_fwd_ok = fwd_ready(vld_p0, we_p0, a3_p0, tnew_p0);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed testbench for pipe_stage_reg with hand-computed expected values.
// Builds with or without PIPE_STAGE_SKID_EN; skid-only checks are guarded.
module tb_pipe_stage_reg;

   logic         clk;
   logic         reset;
   logic         flush;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic [4:0]   in_a3;
   logic         in_we;
   logic [1:0]   in_tnew;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic [4:0]   out_a3;
   logic         out_we;
   logic [1:0]   out_tnew;
   logic         out_fwd_ok;

   int checks = 0;
   int errors = 0;

   pipe_stage_reg dut (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_a3      (in_a3),
      .in_we      (in_we),
      .in_tnew    (in_tnew),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_a3     (out_a3),
      .out_we     (out_we),
      .out_tnew   (out_tnew),
      .out_fwd_ok (out_fwd_ok)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle just after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset     = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b1;
      in_data   = 128'hD1;
      in_a3     = 5'd8;
      in_we     = 1'b1;
      in_tnew   = 2'd2;
      out_ready = 1'b1;

      // Reset held two cycles with a valid beat presented
      step();
      step();
      check("rst_valid", out_valid, 0);
      check("rst_data",  out_data,  0);
      check("rst_a3",    out_a3,    0);
      check("rst_we",    out_we,    0);
      check("rst_tnew",  out_tnew,  0);
      check("rst_fwd",   out_fwd_ok, 0);

      // First edge after reset captures the held beat
      reset = 1'b0;
      step();
      check("post_rst_valid", out_valid, 1);
      check("post_rst_a3",    out_a3,    8);
      check("post_rst_tnew",  out_tnew,  1);
      check("post_rst_ready", in_ready,  1);

      // Stream Tnew 2,1,0 to a3=31 with we=1
      in_a3 = 5'd31;
      in_tnew = 2'd2; in_data = 128'hA2;
      step();
      check("s0_tnew", out_tnew, 1);
      check("s0_fwd",  out_fwd_ok, 0);
      in_tnew = 2'd1; in_data = 128'hA1;
      step();
      check("s1_tnew", out_tnew, 0);
      check("s1_fwd",  out_fwd_ok, 1);
      in_tnew = 2'd0; in_data = 128'hA0;
      step();
      check("s2_tnew", out_tnew, 0);
      check("s2_fwd",  out_fwd_ok, 1);
      check("s2_data", out_data, 128'hA0);

      // Capture Tnew=2 then stall for 3 cycles
      in_tnew = 2'd2; in_data = 128'h5555_AAAA_0000_FFFF_1234_5678_9ABC_DEF0;
      step();
      check("stall_cap_tnew", out_tnew, 1);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      in_data   = 128'hBAD;
      in_tnew   = 2'd3;
      #1;
`ifdef PIPE_STAGE_SKID_EN
      check("stall_ready0", in_ready, 1);
`else
      check("stall_ready0", in_ready, 0);
`endif
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_tnew",  out_tnew,  1);
         check("stall_data",  out_data,  128'h5555_AAAA_0000_FFFF_1234_5678_9ABC_DEF0);
         check("stall_valid", out_valid, 1);
         check("stall_a3",    out_a3,    31);
`ifndef PIPE_STAGE_SKID_EN
         check("stall_ready", in_ready, 0);
`endif
      end

      // Flush beats a simultaneous beat and the stall
      flush    = 1'b1;
      in_valid = 1'b1;
      in_a3    = 5'd9;
      in_data  = 128'hF00D;
      step();
      flush = 1'b0;
      check("flush_valid", out_valid, 0);
      check("flush_we",    out_we,    0);
      check("flush_a3",    out_a3,    0);
      check("flush_fwd",   out_fwd_ok, 0);
      check("flush_data",  out_data,  0);

      // a3=0 with we=1 passes through but never forwards
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_we     = 1'b1;
      in_a3     = 5'd0;
      in_tnew   = 2'd0;
      in_data   = 128'h2E0;
      step();
      check("a3z_valid", out_valid, 1);
      check("a3z_we",    out_we,    1);
      check("a3z_fwd",   out_fwd_ok, 0);

      // Tnew=3 decrements to 2
      in_a3   = 5'd4;
      in_tnew = 2'd3;
      step();
      check("t3_tnew", out_tnew, 2);

      // No valid beat: bubble values load
      in_valid = 1'b0;
      step();
      check("bub_valid", out_valid, 0);
      check("bub_we",    out_we,    0);
      check("bub_data",  out_data,  0);
      check("bub_tnew",  out_tnew,  0);

`ifdef PIPE_STAGE_SKID_EN
      // A then B while stalled: A fills the empty output, B goes to the skid
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_a3     = 5'd3;
      in_tnew   = 2'd1;
      in_data   = 128'hAAAA;
      step();
      check("sk_a_data",  out_data, 128'hAAAA);
      check("sk_a_ready", in_ready, 1);
      in_tnew = 2'd2;
      in_data = 128'hBBBB;
      step();
      check("sk_b_ready",  in_ready, 0);
      check("sk_b_hold",   out_data, 128'hAAAA);
      check("sk_b_tnew_a", out_tnew, 0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      check("sk_drain_data", out_data, 128'hBBBB);
      check("sk_drain_tnew", out_tnew, 1);
      check("sk_drain_rdy",  in_ready, 1);
      step();
      check("sk_nodup_valid", out_valid, 0);
`else
      // Combinational ready follows out_ready while the output is occupied
      in_valid = 1'b1;
      in_data  = 128'hC0DE;
      step();
      out_ready = 1'b0;
      #1;
      check("comb_ready_lo", in_ready, 0);
      out_ready = 1'b1;
      #1;
      check("comb_ready_hi", in_ready, 1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
